// File: rtl/mem_arbiter.sv
// Shares one single-word main-memory port between instruction fetch and data access.
// Each request is registered, issued once, and answered with a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned             ADDRESS_SIZE  = 32,
  parameter int unsigned             DATA_SIZE     = 32,
  parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h8002_0000,
  parameter int unsigned             MEM_SIZE      = 1048578,
  parameter int unsigned             MAX_D_BURST   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  output logic                    i_ack,
  output logic [DATA_SIZE-1:0]    i_rdata,
  output logic                    i_err,
  input  logic                    d_req,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [DATA_SIZE-1:0]    d_wdata,
  input  logic                    d_wren,
  input  logic                    d_byte,
  input  logic                    d_ubyte,
  output logic                    d_ack,
  output logic [DATA_SIZE-1:0]    d_rdata,
  output logic                    d_err,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  output logic [1:0]              mem_acc_size,
  output logic                    mem_wren,
  output logic                    mem_enable,
  output logic                    mem_byteOnly,
  output logic                    mem_ubyte,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  input  logic                    mem_busy
);

  localparam int unsigned SW = $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0] LP_MAXB = SW'(MAX_D_BURST);
  localparam logic [ADDRESS_SIZE:0] LP_MEM = (ADDRESS_SIZE + 1)'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  r_state, w_next;
  logic                    r_owner, r_err, r_wren, r_byte, r_ubyte;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [DATA_SIZE-1:0]    r_wdata;
  logic [SW-1:0]           r_starve;

  logic                    w_any, w_grant_d, w_byte, w_err, w_issue, w_resp;
  logic [ADDRESS_SIZE-1:0] w_addr;
  logic [ADDRESS_SIZE:0]   w_off, w_span;
  logic [DATA_SIZE-1:0]    w_rd;

  // Data normally wins; a fetch that has watched MAX_D_BURST data grants goes next.
  assign w_any     = i_req | d_req;
  assign w_grant_d = d_req & ~(i_req & (r_starve == LP_MAXB));
  assign w_addr    = w_grant_d ? d_addr : i_addr;
  assign w_byte    = w_grant_d & d_byte;

  // One extra bit keeps offset + span from wrapping near the top of the address space.
  assign w_off  = {1'b0, w_addr} - {1'b0, START_ADDRESS};
  assign w_span = w_byte ? (ADDRESS_SIZE + 1)'(1) : (ADDRESS_SIZE + 1)'(4);
  assign w_err  = (w_addr < START_ADDRESS) || ((w_off + w_span) > LP_MEM) ||
                  (!w_byte && (w_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_err    <= 1'b0;
      r_wren   <= 1'b0;
      r_byte   <= 1'b0;
      r_ubyte  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_starve <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_grant_d;
        r_err   <= w_err;
        r_addr  <= w_addr;
        r_wdata <= w_grant_d ? d_wdata : '0;
        r_wren  <= w_grant_d & d_wren;
        r_byte  <= w_byte;
        r_ubyte <= w_grant_d & d_ubyte;
        if (w_grant_d && i_req) begin
          if (r_starve != LP_MAXB) r_starve <= r_starve + SW'(1);
        end else begin
          r_starve <= '0;
        end
      end
    end
  end

  // Memory is never enabled while reset is asserted, so a reset mid-access cannot write.
  assign w_issue = (r_state == ISSUE) && !r_err && rst_n;
  assign w_resp  = (r_state == RESP);
  assign w_rd    = (w_resp && !r_err && !r_wren) ? mem_d_out : '0;

  always_comb begin
    w_next       = r_state;
    mem_enable   = w_issue;
    mem_wren     = w_issue & r_wren;
    mem_byteOnly = r_byte;
    mem_ubyte    = r_ubyte;
    mem_addr     = r_addr;
    mem_d_in     = r_wdata;
    mem_acc_size = 2'b00;
    i_ack        = w_resp & ~r_owner;
    d_ack        = w_resp & r_owner;
    i_err        = w_resp & ~r_owner & r_err;
    d_err        = w_resp & r_owner & r_err;
    i_rdata      = r_owner ? '0 : w_rd;
    d_rdata      = r_owner ? w_rd : '0;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   if (r_err || !mem_busy) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner cases, then random traffic against a
// transaction-level reference model with its own copy of memory.
module tb_mem_arbiter;
  localparam logic [31:0] START = 32'h8002_0000;
  localparam int unsigned MSZ   = 1048578;
  localparam int unsigned MAXB  = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_req = 1'b0, i_ack, i_err;
  logic [31:0] i_addr = '0, i_rdata;
  logic        d_req = 1'b0, d_wren = 1'b0, d_byte = 1'b0, d_ubyte = 1'b0, d_ack, d_err;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [31:0] mem_addr, mem_d_in, mem_d_out = '0;
  logic [1:0]  mem_acc_size;
  logic        mem_wren, mem_enable, mem_byteOnly, mem_ubyte, mem_busy = 1'b0;

  int n_tot = 0, n_bad = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren),
    .d_byte(d_byte), .d_ubyte(d_ubyte), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_acc_size(mem_acc_size),
    .mem_wren(mem_wren), .mem_enable(mem_enable), .mem_byteOnly(mem_byteOnly),
    .mem_ubyte(mem_ubyte), .mem_d_out(mem_d_out), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  // Sparse byte store: low window of memory plus the last 8 bytes before the end.
  function automatic int bidx(input logic [31:0] a);
    logic [31:0] off;
    off = a - START;
    if (off < 32'd512) return int'(off);
    if (off >= MSZ - 8 && off < MSZ) return 512 + int'(off - (MSZ - 8));
    return 600;
  endfunction

  logic [7:0] bfm  [0:519] = '{16: 8'h8F, 17: 8'hBF, 18: 8'h00, 19: 8'h14, default: 8'h00};
  logic [7:0] refm [0:519] = '{default: 8'h00};

  // Big-endian single-word main memory, synchronous access, honours mem_busy.
  always @(posedge clk) begin
    if (mem_enable && !mem_busy) begin
      if (mem_wren) begin
        if (mem_byteOnly) bfm[bidx(mem_addr)] <= mem_d_in[7:0];
        else for (int k = 0; k < 4; k++) bfm[bidx(mem_addr + 32'(k))] <= mem_d_in[31-8*k -: 8];
      end else if (mem_byteOnly) begin
        mem_d_out <= mem_ubyte ? {24'h0, bfm[bidx(mem_addr)]}
                               : {{24{bfm[bidx(mem_addr)][7]}}, bfm[bidx(mem_addr)]};
      end else begin
        mem_d_out <= {bfm[bidx(mem_addr)], bfm[bidx(mem_addr + 32'd1)],
                      bfm[bidx(mem_addr + 32'd2)], bfm[bidx(mem_addr + 32'd3)]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input bit byt);
    longint off;
    off = longint'(a) - longint'(START);
    if (off < 0) return 1'b1;
    if (off + (byt ? 1 : 4) > longint'(MSZ)) return 1'b1;
    if (!byt && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] gen_addr(input bit byt);
    logic [31:0] a;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0)      a = START - $urandom_range(1, 16);
    else if (r == 1) a = START + MSZ - 6 + $urandom_range(0, 7);
    else             a = START + 32'h100 + $urandom_range(0, 63);
    if (!byt && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic xact(input bit pd_, input logic [31:0] a, input logic [31:0] wd,
                      input bit wr, input bit by, input bit ub, input int busy_n,
                      output logic [31:0] rd, output logic er, output int lat, output int en_n);
    bit got;
    got = 1'b0; lat = 0; en_n = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    if (pd_) begin
      d_req = 1'b1; d_addr = a; d_wdata = wd; d_wren = wr; d_byte = by; d_ubyte = ub;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (mem_enable) en_n++;
      if (busy_n > 0 && k == 0) mem_busy = 1'b1;
      if (busy_n > 0 && k == busy_n) mem_busy = 1'b0;
      if (pd_ ? d_ack : i_ack) begin
        got = 1'b1;
        rd  = pd_ ? d_rdata : i_rdata;
        er  = pd_ ? d_err : i_err;
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_wren = 1'b0; d_byte = 1'b0; d_ubyte = 1'b0; mem_busy = 1'b0;
    chk("ack_seen", 32'(got), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, en;
    int          nack, last, cyc;
    int          e, free_at, ack_e, starve;
    bit          pi, pd, c_port, c_err, c_wren, byt, wr, ub;
    logic [31:0] c_rd, a, wd;
    logic [7:0]  b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iack", i_ack, 0);       chk("rst_dack", d_ack, 0);
    chk("rst_ierr", i_err, 0);       chk("rst_derr", d_err, 0);
    chk("rst_en", mem_enable, 0);    chk("rst_wren", mem_wren, 0);
    chk("rst_byte", mem_byteOnly, 0); chk("rst_ubyte", mem_ubyte, 0);
    chk("rst_irdata", i_rdata, 0);   chk("rst_drdata", d_rdata, 0);
    chk("rst_maddr", mem_addr, 0);   chk("rst_mdin", mem_d_in, 0);
    chk("rst_accsz", 32'(mem_acc_size), 0);
    rst_n = 1'b1;

    // Reset while a store sits in ISSUE: it must be dropped without writing.
    d_req = 1'b1; d_addr = START; d_wdata = 32'hDEAD_BEEF; d_wren = 1'b1; d_byte = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_issue_en", mem_enable, 1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_en", mem_enable, 0);
    chk("midrst_dack", d_ack, 0);
    d_req = 1'b0; d_wren = 1'b0; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_dack2", d_ack, 0);
    xact(1, START, 0, 0, 0, 0, 0, rd, er, lat, en);
    chk("midrst_readback", rd, 0);

    xact(0, START + 32'h10, 0, 0, 0, 0, 0, rd, er, lat, en);
    chk("fetch_rdata", rd, 32'h8FBF_0014); chk("fetch_err", 32'(er), 0);
    chk("fetch_lat", lat, 2);              chk("fetch_en", en, 1);

    xact(1, START + 3, 32'h0000_00F0, 1, 1, 0, 0, rd, er, lat, en);
    chk("sb_rdata", rd, 0); chk("sb_err", 32'(er), 0);
    xact(1, START + 3, 0, 0, 1, 0, 0, rd, er, lat, en);
    chk("lb_signed", rd, 32'hFFFF_FFF0);
    xact(1, START + 3, 0, 0, 1, 1, 0, rd, er, lat, en);
    chk("lb_unsigned", rd, 32'h0000_00F0);

    xact(1, START + 2, 0, 0, 0, 0, 0, rd, er, lat, en);
    chk("misalign_err", 32'(er), 1); chk("misalign_rd", rd, 0);
    chk("misalign_en", en, 0);       chk("misalign_lat", lat, 2);
    xact(0, 32'h8000_0000, 0, 0, 0, 0, 0, rd, er, lat, en);
    chk("below_err", 32'(er), 1); chk("below_rd", rd, 0); chk("below_en", en, 0);

    xact(1, START + MSZ - 6, 0, 0, 0, 0, 0, rd, er, lat, en);
    chk("top_word_ok", 32'(er), 0);
    xact(1, START + MSZ - 2, 0, 0, 0, 0, 0, rd, er, lat, en);
    chk("top_word_err", 32'(er), 1);
    xact(1, START + MSZ - 1, 0, 0, 1, 0, 0, rd, er, lat, en);
    chk("top_byte_ok", 32'(er), 0);
    xact(1, START + MSZ, 0, 0, 1, 0, 0, rd, er, lat, en);
    chk("top_byte_err", 32'(er), 1);

    xact(1, START + 32'h10, 0, 0, 0, 0, 2, rd, er, lat, en);
    chk("busy_rdata", rd, 32'h8FBF_0014); chk("busy_lat", lat, 4); chk("busy_en", en, 3);

    // Both requesters held: every fifth grant goes to fetch, one access per 3 cycles.
    @(negedge clk);
    i_req = 1'b1; i_addr = START + 32'h10; d_req = 1'b1; d_addr = START + 32'h10; d_wren = 1'b0;
    nack = 0; last = -1; cyc = 0;
    for (int k = 0; k < 60 && nack < 10; k++) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (i_ack || d_ack) begin
        chk("starve_owner_i", i_ack, (nack % 5 == 4) ? 1 : 0);
        chk("starve_excl", i_ack & d_ack, 0);
        if (last >= 0) chk("starve_gap", cyc - last, 3);
        last = cyc; nack++;
      end
    end
    chk("starve_count", nack, 10);
    i_req = 1'b0; d_req = 1'b0;

    // Random traffic; the model decides grants per edge from the arbitration rules.
    repeat (2) @(negedge clk);
    e = 0; free_at = 1; ack_e = -10; starve = 0; pi = 0; pd = 0;
    c_port = 0; c_err = 0; c_wren = 0; c_rd = '0;
    for (int t = 0; t < 3000; t++) begin
      chk("r_iack", i_ack, (e == ack_e && !c_port) ? 1 : 0);
      chk("r_dack", d_ack, (e == ack_e && c_port) ? 1 : 0);
      chk("r_en", mem_enable, (e == ack_e - 1 && !c_err) ? 1 : 0);
      chk("r_wren", mem_wren, (e == ack_e - 1 && !c_err && c_wren) ? 1 : 0);
      if (e == ack_e) begin
        if (c_port) begin
          chk("r_drdata", d_rdata, c_rd); chk("r_derr", 32'(d_err), 32'(c_err));
          pd = 0; d_req = 1'b0;
        end else begin
          chk("r_irdata", i_rdata, c_rd); chk("r_ierr", 32'(i_err), 32'(c_err));
          pi = 0; i_req = 1'b0;
        end
      end
      if (!pi && $urandom_range(0, 2) == 0) begin
        pi = 1; i_req = 1'b1; i_addr = gen_addr(0);
      end
      if (!pd && $urandom_range(0, 2) == 0) begin
        pd = 1; d_req = 1'b1;
        d_byte = 1'($urandom_range(0, 1)); d_wren = 1'($urandom_range(0, 1));
        d_ubyte = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_addr = gen_addr(d_byte);
      end
      if (e + 1 >= free_at && (pi || pd)) begin
        c_port = pd && !(pi && starve == int'(MAXB));
        starve = (c_port && pi) ? ((starve + 1 > int'(MAXB)) ? int'(MAXB) : starve + 1) : 0;
        a   = c_port ? d_addr : i_addr;
        byt = c_port && d_byte;
        wr  = c_port && d_wren;
        ub  = c_port && d_ubyte;
        wd  = d_wdata;
        c_err  = model_err(a, byt);
        c_wren = wr;
        c_rd   = '0;
        if (!c_err && wr) begin
          if (byt) refm[bidx(a)] = wd[7:0];
          else for (int k = 0; k < 4; k++) refm[bidx(a + 32'(k))] = wd[31-8*k -: 8];
        end else if (!c_err) begin
          if (byt) begin
            b = refm[bidx(a)];
            c_rd = ub ? {24'h0, b} : {{24{b[7]}}, b};
          end else begin
            c_rd = {refm[bidx(a)], refm[bidx(a + 32'd1)], refm[bidx(a + 32'd2)], refm[bidx(a + 32'd3)]};
          end
        end
        ack_e   = e + 2;
        free_at = e + 4;
      end
      @(posedge clk); e++;
      @(negedge clk);
    end
    i_req = 1'b0; d_req = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the unified main memory (mainMem).
- Shares the single memory port between the instruction-fetch requester (read-only, word) and the data requester (load/store, word or byte).
- Registers each granted request, drives one single-word memory access, returns read data with a one-cycle ack.
- Rejects misaligned and out-of-range accesses without touching memory.

Parameters:
- ADDRESS_SIZE, 32, address width
- DATA_SIZE, 32, data width
- START_ADDRESS, 32'h80020000, first valid byte address of main memory
- MEM_SIZE, 1048578, memory size in bytes
- MAX_D_BURST, 4, consecutive data grants allowed while an instruction request waits

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  fetch request; i_addr held stable until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle completion pulse for fetch
- i_rdata  out  32  fetched word; valid while i_ack=1
- i_err  out  1  fetch error; valid while i_ack=1
- d_req  in  1  data request; d_* inputs held stable until d_ack
- d_addr  in  32  data byte address
- d_wdata  in  32  store data; byte stores use bits [24:31]
- d_wren  in  1  1=store, 0=load
- d_byte  in  1  byte access
- d_ubyte  in  1  zero-extend a byte load (else sign-extend)
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  32  load data; valid while d_ack=1
- d_err  out  1  data error; valid while d_ack=1
- mem_addr  out  32  to memory addr
- mem_d_in  out  32  to memory d_in
- mem_acc_size  out  2  constant 2'b00 (single word)
- mem_wren, mem_enable, mem_byteOnly, mem_ubyte  out  1 each  memory controls
- mem_d_out  in  32  memory read data
- mem_busy  in  1  memory busy

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset (rst_n=0 at posedge) forces IDLE from any state, including mid-access.
- Reset values: all acks, errs, mem_enable, mem_wren, mem_byteOnly and mem_ubyte = 0. All rdata, mem_addr and mem_d_in = 0. Starvation counter and owner register = 0.
- IDLE: if any request is pending, pick a winner, latch its address, wdata and controls into registers, latch owner (0=I, 1=D), then go to ISSUE.
- Arbitration priority: data wins over fetch.
- Exception: if i_req=1 and the starvation counter = MAX_D_BURST, fetch wins.
- Starvation counter: increments on each data grant made while i_req=1; clears on any fetch grant, or on any grant made while i_req=0. It saturates at MAX_D_BURST.
- Error check at latch time: err = addr < START_ADDRESS, or addr - START_ADDRESS + 4 > MEM_SIZE (word), or addr - START_ADDRESS + 1 > MEM_SIZE (byte), or a word access with addr[30:31] != 0.
- ISSUE, no error:
  - mem_enable=1; mem_addr, mem_d_in and controls are driven from the registers.
  - mem_wren=1 only for a data store; the fetch path forces mem_wren=0 and mem_byteOnly=0.
  - If mem_busy=1, stay in ISSUE with mem_enable held; otherwise go to RESP on the next edge.
- ISSUE, error: mem_enable=0, mem_wren=0; go to RESP.
- RESP:
  - Assert the owner's ack for exactly one cycle.
  - rdata = mem_d_out for a non-error read; rdata = 0 for stores and for errors.
  - err = latched error flag.
  - Go to IDLE.
- Outside ISSUE, mem_enable=0 and mem_wren=0, so memory is never written spuriously.
- Latency: request sampled in IDLE at edge N, ack high during cycle N+2. Minimum 3 cycles per access. No overlap between accesses.
- Requester handshake: the requester may drop req, or present a new request, in the cycle after its ack. A req still high in IDLE after ack is treated as a new request.
- Simultaneous i_req and d_req: exactly one is granted. The loser keeps its req and is served in a later IDLE; it never receives an ack without a grant.
- A req deasserted before its ack is a protocol violation; behaviour is undefined and is not checked.

Test Plan:
- Reset mid-access: d_req store at 32'h80020000, assert rst_n=0 during ISSUE -> next cycle IDLE, mem_enable=0, no d_ack, memory unchanged on readback.
- Single fetch: memory word at 32'h80020010 = 32'h8FBF0014; i_req with i_addr=32'h80020010 -> i_ack 2 cycles after sample, i_rdata=32'h8FBF0014, i_err=0.
- Store/load bytes: store d_wdata=32'h000000F0, d_byte=1 at 32'h80020003. Signed load -> d_rdata=32'hFFFFFFF0. Unsigned load (d_ubyte=1) -> 32'h000000F0.
- Errors: word load at 32'h80020002 and fetch at 32'h80000000 -> ack with err=1, rdata=0, mem_enable never asserted.
- Starvation: d_req and i_req both held continuously with MAX_D_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I. Every access takes 3 cycles.
- mem_busy forced high 2 cycles during ISSUE -> mem_enable held for those cycles, ack delayed by 2 cycles, data correct.
